fetch_sequencer: RTL and testbench

//  Sequences instruction fetch for the MIPS core: owns the word-addressed program counter and issues requests to instruction memory.

---
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch sequencer for the MIPS core. It owns the word-addressed
//   program counter and requests each instruction from instruction memory. It
//   waits for the memory to acknowledge, then presents the instruction to
//   decode for one issue slot. When that instruction retires, it selects the
//   next PC: jump target, branch target or the next sequential word.
//
// Ports
//   clk            : clock, rising edge
//   reset          : synchronous, active-high; overrides everything
//   run            : start/resume fetching from pc_out (IDLE/HALTED only)
//   halt_req       : go to HALTED after the current issue slot retires
//   stall          : hold the current issue slot
//   jump           : retire with PC <= jump_address (has priority)
//   jump_address   : absolute word address
//   pc_src         : branch taken, retire with PC <= pc_out + branch_offset
//   branch_offset  : signed word offset relative to pc_out
//   imem_req       : fetch request, held until imem_ack
//   imem_addr      : fetch address (equals pc_out)
//   imem_ack       : instruction data valid this cycle
//   imem_rdata     : instruction word
//   instr_valid    : instr_out is valid for decode
//   instr_out      : registered instruction word
//   pc_out         : PC of the instruction being fetched/issued
//   busy           : high while fetching or issuing
//   retired_count  : number of retired instructions, wraps
module fetch_sequencer #(
  parameter int         N        = 32,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         halt_req,
  input  logic         stall,
  input  logic         jump,
  input  logic [N-1:0] jump_address,
  input  logic         pc_src,
  input  logic [N-1:0] branch_offset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] pc_out,
  output logic         busy,
  output logic [N-1:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] count_q, count_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  // Next-state, next-PC and retire-count selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      IDLE, HALTED: begin
        if (run) begin
          state_d = FETCH;
        end else begin
          state_d = state_q;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end else begin
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (!stall) begin
          // Retire: control inputs are only looked at on this cycle.
          count_d = count_q + ONE;
          if (jump) begin
            pc_d = jump_address;
          end else if (pc_src) begin
            pc_d = pc_q + branch_offset;
          end else begin
            pc_d = pc_q + ONE;
          end
          if (halt_req) begin
            state_d = HALTED;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop directly
  always_comb begin
    req_d   = (state_d == FETCH);
    valid_d = (state_d == ISSUE);
    busy_d  = (state_d == FETCH) || (state_d == ISSUE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= {N{1'b0}};
      count_q <= {N{1'b0}};
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign instr_valid   = valid_q;
  assign instr_out     = instr_q;
  assign pc_out        = pc_q;
  assign busy          = busy_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        halt_req;
  logic        stall;
  logic        jump;
  logic [31:0] jump_address;
  logic        pc_src;
  logic [31:0] branch_offset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        busy;
  logic [31:0] retired_count;

  int checks;
  int errors;

  // Reference model: what the fetch unit is doing, in plain terms.
  //   m_fetching : a memory request is outstanding
  //   m_issuing  : an instruction is sitting in the issue slot
  //   (neither   : idle or halted, waiting for run)
  bit          m_fetching;
  bit          m_issuing;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;

  fetch_sequencer #(.N(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .halt_req      (halt_req),
    .stall         (stall),
    .jump          (jump),
    .jump_address  (jump_address),
    .pc_src        (pc_src),
    .branch_offset (branch_offset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .busy          (busy),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the behavioural rules for one clock edge using the inputs held now.
  task automatic model_edge();
    if (reset) begin
      m_fetching = 1'b0;
      m_issuing  = 1'b0;
      m_pc       = 32'h0;
      m_instr    = 32'h0;
      m_retired  = 32'h0;
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_instr    = imem_rdata;
        m_fetching = 1'b0;
        m_issuing  = 1'b1;
      end
    end else if (m_issuing) begin
      if (!stall) begin
        m_retired = m_retired + 32'd1;
        if (jump)        m_pc = jump_address;
        else if (pc_src) m_pc = m_pc + branch_offset;
        else             m_pc = m_pc + 32'd1;
        m_issuing  = 1'b0;
        m_fetching = !halt_req;
      end
    end else if (run) begin
      m_fetching = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".req"},     {31'd0, imem_req},    {31'd0, m_fetching});
    check({tag, ".valid"},   {31'd0, instr_valid}, {31'd0, m_issuing});
    check({tag, ".busy"},    {31'd0, busy},        {31'd0, m_fetching | m_issuing});
    check({tag, ".pc"},      pc_out,               m_pc);
    check({tag, ".instr"},   instr_out,            m_instr);
    check({tag, ".retired"}, retired_count,        m_retired);
    if (m_fetching) check({tag, ".addr"}, imem_addr, m_pc);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    reset = 1'b0; run = 1'b0; halt_req = 1'b0; stall = 1'b0;
    jump = 1'b0; jump_address = 32'h0; pc_src = 1'b0; branch_offset = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic fetch_ack(input string tag, input logic [31:0] data);
    imem_ack = 1'b1; imem_rdata = data;
    cyc(tag);
    imem_ack = 1'b0;
  endtask

  task automatic retire(input string tag, input logic j, input logic [31:0] ja,
                        input logic ps, input logic [31:0] off, input logic h);
    jump = j; jump_address = ja; pc_src = ps; branch_offset = off; halt_req = h;
    cyc(tag);
    jump = 1'b0; pc_src = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    m_fetching = 1'b0; m_issuing = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0;

    // Reset
    reset = 1'b1;
    cyc("rst0");
    cyc("rst1");
    reset = 1'b0;
    check("rst.pc", pc_out, 32'h0);

    // 1: immediate ack
    run = 1'b1;
    cyc("t1.run");
    run = 1'b0;
    check("t1.addr", imem_addr, 32'h0);
    check("t1.req", {31'd0, imem_req}, 32'd1);
    fetch_ack("t1.ack", 32'hA);
    check("t1.instr", instr_out, 32'hA);
    retire("t1.ret", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("t1.pc", pc_out, 32'h1);
    check("t1.cnt", retired_count, 32'h1);

    // 2: ack delayed three cycles; request and address held
    for (int i = 0; i < 3; i++) begin
      cyc("t2.wait");
      check("t2.addr_stable", imem_addr, 32'h1);
    end
    fetch_ack("t2.ack", 32'h1234_5678);
    retire("t2.ret_j10", 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);

    // 3: jump priority, branch forward, branch backward
    fetch_ack("t3.ack_a", 32'h1);
    retire("t3.jump_pri", 1'b1, 32'h40, 1'b1, 32'd5, 1'b0);
    check("t3.pc_40", pc_out, 32'h40);
    fetch_ack("t3.ack_b", 32'h2);
    retire("t3.back_10", 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    fetch_ack("t3.ack_c", 32'h3);
    retire("t3.branch", 1'b0, 32'h40, 1'b1, 32'd5, 1'b0);
    check("t3.pc_15", pc_out, 32'h15);
    fetch_ack("t3.ack_d", 32'h4);
    retire("t3.back_10b", 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    fetch_ack("t3.ack_e", 32'h5);
    retire("t3.branch_neg", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    check("t3.pc_0f", pc_out, 32'h0F);

    // 4: stall holds the issue slot; jump/halt ignored while stalled
    fetch_ack("t4.ack", 32'hBEEF);
    stall = 1'b1; jump = 1'b1; jump_address = 32'h99; halt_req = 1'b1;
    cyc("t4.stall1");
    cyc("t4.stall2");
    check("t4.valid_held", {31'd0, instr_valid}, 32'd1);
    check("t4.pc_held", pc_out, 32'h0F);
    stall = 1'b0; jump = 1'b0; halt_req = 1'b0;
    cyc("t4.retire");
    check("t4.pc_after", pc_out, 32'h10);

    // 5: halt on a retire at pc 7, then resume
    fetch_ack("t5.ack_a", 32'h6);
    retire("t5.to7", 1'b1, 32'h7, 1'b0, 32'h0, 1'b0);
    fetch_ack("t5.ack_b", 32'h7);
    retire("t5.halt", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("t5.pc8", pc_out, 32'h8);
    check("t5.busy", {31'd0, busy}, 32'd0);
    cyc("t5.halted_idle");
    run = 1'b1;
    cyc("t5.run");
    run = 1'b0;
    check("t5.addr8", imem_addr, 32'h8);

    // 6: reset mid-fetch, late ack ignored; PC wraps on sequential retire
    reset = 1'b1;
    cyc("t6.reset");
    reset = 1'b0;
    fetch_ack("t6.late_ack", 32'hDEAD);
    check("t6.valid", {31'd0, instr_valid}, 32'd0);
    check("t6.pc", pc_out, 32'h0);
    check("t6.cnt", retired_count, 32'h0);
    run = 1'b1;
    cyc("t6.run");
    run = 1'b0;
    fetch_ack("t6.ack_a", 32'h11);
    retire("t6.to_max", 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    fetch_ack("t6.ack_b", 32'h22);
    retire("t6.wrap", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("t6.pc_wrap", pc_out, 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      run           = ($urandom_range(0, 3) == 0);
      halt_req      = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      jump          = ($urandom_range(0, 4) == 0);
      jump_address  = $urandom;
      pc_src        = ($urandom_range(0, 3) == 0);
      branch_offset = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 16)) - 8);
      imem_ack      = ($urandom_range(0, 2) == 0);
      imem_rdata    = $urandom;
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
